// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_controller
//  Description : Seven-source interrupt controller that feeds the datapath's
//                3-bit interrupt code. Request lines are synchronised and
//                rising edges are latched as pending. Each source is then
//                qualified by a per-source mask and a global enable. The
//                highest-priority eligible source (lowest index) is dispatched
//                as a one-cycle code. Further dispatch is blocked until the
//                control unit signals end-of-interrupt, so interrupts never
//                nest.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1  system clock, rising edge
//    reset        in   1  synchronous, active-high; clears all state
//    i_irq        in   7  asynchronous requests; i_irq[i] maps to code i+1
//    i_eoi        in   1  end-of-interrupt pulse from the control unit
//    i_cfg_we     in   1  configuration write strobe
//    i_cfg_sel    in   1  register select: 0 = control, 1 = pending
//    i_cfg_wdata  in   8  configuration write data
//    o_cfg_rdata  out  8  read data, combinational on i_cfg_sel
//    o_irq_code   out  3  registered interrupt code, 0 = none
//    o_in_service out  1  registered, high while a handler is active
//    o_active_src out  3  registered code of the source in service
// ============================================================================
module interrupt_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int N_SRC       = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] i_irq,
  input  logic             i_eoi,
  input  logic             i_cfg_we,
  input  logic             i_cfg_sel,
  input  logic [7:0]       i_cfg_wdata,
  output logic [7:0]       o_cfg_rdata,
  output logic [2:0]       o_irq_code,
  output logic             o_in_service,
  output logic [2:0]       o_active_src
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_SERVICE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][N_SRC-1:0] r_sync;
  logic [N_SRC-1:0]                  r_hist;
  logic [N_SRC-1:0]                  r_pend;
  logic [N_SRC-1:0]                  r_mask;
  logic                              r_gie;
  state_t                            r_state;
  logic [2:0]                        r_irq_code;
  logic                              r_in_service;
  logic [2:0]                        r_active_src;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [N_SRC-1:0] w_sync_out;
  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_clr;
  logic [2:0]       w_pri_code;
  logic [N_SRC-1:0] w_pri_onehot;
  state_t           w_state_nxt;
  logic [2:0]       w_code_nxt;
  logic             w_insvc_nxt;
  logic [2:0]       w_active_nxt;
  logic [N_SRC-1:0] w_disp_clr;

  // --------------------------------------------------------------------------
  // Synchroniser chain, edge history and edge detect
  // --------------------------------------------------------------------------
  assign w_sync_out = r_sync[SYNC_STAGES-1];
  // A held-high request yields a single edge because the history flop
  // follows the synchronised level one cycle later.
  assign w_edge     = w_sync_out & ~r_hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_hist <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
      r_hist <= w_sync_out;
    end
  end

  // --------------------------------------------------------------------------
  // Eligibility and fixed priority (lowest index wins)
  // --------------------------------------------------------------------------
  assign w_elig = r_pend & r_mask & {N_SRC{r_gie}};

  // Scanning from the top down lets the lowest eligible index overwrite
  // any higher one, which gives the fixed priority order.
  always_comb begin
    w_pri_code   = 3'd0;
    w_pri_onehot = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_pri_code      = 3'(i + 1);
        w_pri_onehot    = '0;
        w_pri_onehot[i] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Dispatch FSM: next state and next registered outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = 3'd0;
    w_insvc_nxt  = r_in_service;
    w_active_nxt = r_active_src;
    w_disp_clr   = '0;
    case (r_state)
      S_IDLE: begin
        if (|w_elig) begin
          w_state_nxt  = S_DISPATCH;
          w_code_nxt   = w_pri_code;
          w_active_nxt = w_pri_code;
          w_insvc_nxt  = 1'b1;
          w_disp_clr   = w_pri_onehot;
        end
      end
      S_DISPATCH: begin
        // The code is held for a single cycle; eoi has no effect here.
        w_state_nxt = S_SERVICE;
      end
      S_SERVICE: begin
        if (i_eoi) begin
          w_state_nxt  = S_IDLE;
          w_insvc_nxt  = 1'b0;
          w_active_nxt = 3'd0;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_insvc_nxt  = 1'b0;
        w_active_nxt = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_irq_code   <= 3'd0;
      r_in_service <= 1'b0;
      r_active_src <= 3'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_irq_code   <= w_code_nxt;
      r_in_service <= w_insvc_nxt;
      r_active_src <= w_active_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Pending register: set by edges, cleared by dispatch or write-1-to-clear.
  // The set term is OR-ed in last so a coinciding edge survives the clear.
  // --------------------------------------------------------------------------
  assign w_w1c = (i_cfg_we && i_cfg_sel) ? i_cfg_wdata[N_SRC-1:0] : '0;
  assign w_clr = w_w1c | w_disp_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_edge;
    end
  end

  // --------------------------------------------------------------------------
  // Control register: mask and global enable
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
      r_gie  <= 1'b0;
    end else if (i_cfg_we && !i_cfg_sel) begin
      r_mask <= i_cfg_wdata[N_SRC-1:0];
      r_gie  <= i_cfg_wdata[7];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_cfg_rdata  = i_cfg_sel ? {r_in_service, r_pend} : {r_gie, r_mask};
  assign o_irq_code   = r_irq_code;
  assign o_in_service = r_in_service;
  assign o_active_src = r_active_src;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_controller
//  Description : Self-checking bench for interrupt_controller. Directed
//                scenarios followed by a randomized run; every cycle is
//                compared against a behavioural model of the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] irq = '0;
  logic       eoi = 1'b0;
  logic       cfg_we = 1'b0;
  logic       cfg_sel = 1'b0;
  logic [7:0] cfg_wdata = '0;
  logic [7:0] cfg_rdata;
  logic [2:0] irq_code;
  logic       in_service;
  logic [2:0] active_src;

  int checks = 0;
  int failures = 0;

  interrupt_controller #(.SYNC_STAGES(SYNC), .N_SRC(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_irq       (irq),
    .i_eoi       (eoi),
    .i_cfg_we    (cfg_we),
    .i_cfg_sel   (cfg_sel),
    .i_cfg_wdata (cfg_wdata),
    .o_cfg_rdata (cfg_rdata),
    .o_irq_code  (irq_code),
    .o_in_service(in_service),
    .o_active_src(active_src)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Behavioural model. m_hq[j] is the request vector sampled j+1 edges ago;
  // a rising edge of the synchronised view appears SYNC edges after sampling.
  // m_phase: 0 idle, 1 code being presented, 2 handler running.
  // --------------------------------------------------------------------------
  logic [6:0] m_hq [0:SYNC];
  logic [6:0] m_pend = '0;
  logic [6:0] m_mask = '0;
  logic       m_gie = 1'b0;
  int         m_phase = 0;
  logic [2:0] m_code = '0;
  logic [2:0] m_active = '0;
  logic       m_insvc = 1'b0;

  task automatic model_step();
    logic [6:0] v_set;
    logic [6:0] v_clr;
    logic [6:0] v_elig;
    int         v_src;
    if (reset) begin
      for (int j = 0; j <= SYNC; j++) m_hq[j] = '0;
      m_pend = '0; m_mask = '0; m_gie = 1'b0;
      m_phase = 0; m_code = '0; m_active = '0; m_insvc = 1'b0;
      return;
    end
    v_set = m_hq[SYNC-1] & ~m_hq[SYNC];
    for (int j = SYNC; j > 0; j--) m_hq[j] = m_hq[j-1];
    m_hq[0] = irq;
    v_elig = m_gie ? (m_pend & m_mask) : 7'd0;
    v_clr  = (cfg_we && cfg_sel) ? cfg_wdata[6:0] : 7'd0;
    m_code = 3'd0;
    if (m_phase == 0) begin
      if (v_elig != 0) begin
        v_src = 0;
        for (int i = 6; i >= 0; i--) if (v_elig[i]) v_src = i + 1;
        v_clr    = v_clr | 7'(1 << (v_src - 1));
        m_phase  = 1;
        m_code   = 3'(v_src);
        m_active = 3'(v_src);
        m_insvc  = 1'b1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (eoi) begin
      m_phase  = 0;
      m_insvc  = 1'b0;
      m_active = 3'd0;
    end
    m_pend = (m_pend & ~v_clr) | v_set;
    if (cfg_we && !cfg_sel) begin
      m_mask = cfg_wdata[6:0];
      m_gie  = cfg_wdata[7];
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("model_irq_code", {5'd0, irq_code}, {5'd0, m_code});
    chk("model_in_service", {7'd0, in_service}, {7'd0, m_insvc});
    chk("model_active_src", {5'd0, active_src}, {5'd0, m_active});
    chk("model_cfg_rdata", cfg_rdata, cfg_sel ? {m_insvc, m_pend} : {m_gie, m_mask});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg_write(input logic sel, input logic [7:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic [6:0] bits);
    irq = bits;
    tick();
    irq = '0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  initial begin
    int n_disp;
    for (int j = 0; j <= SYNC; j++) m_hq[j] = '0;

    // Reset state
    reset = 1'b1;
    ticks(2);
    chk("reset_code", {5'd0, irq_code}, 8'h00);
    chk("reset_insvc", {7'd0, in_service}, 8'h00);
    chk("reset_ctrl", cfg_rdata, 8'h00);
    reset = 1'b0;

    // Single source: latency and one-cycle code
    cfg_write(1'b0, 8'h81);
    cfg_sel = 1'b1;
    pulse(7'h01);
    ticks(2);
    chk("t1_pend", cfg_rdata, 8'h01);
    tick();
    chk("t1_code", {5'd0, irq_code}, 8'h01);
    chk("t1_active", {5'd0, active_src}, 8'h01);
    tick();
    chk("t1_code_drop", {5'd0, irq_code}, 8'h00);
    chk("t1_insvc", {7'd0, in_service}, 8'h01);
    ticks(3);
    do_eoi();
    chk("t1_eoi_insvc", {7'd0, in_service}, 8'h00);
    chk("t1_eoi_active", {5'd0, active_src}, 8'h00);

    // Two simultaneous sources: priority then back-to-back
    cfg_write(1'b0, 8'hFF);
    cfg_sel = 1'b1;
    pulse(7'h12);
    ticks(3);
    chk("t2_first", {5'd0, irq_code}, 8'h02);
    chk("t2_pend", {1'b0, cfg_rdata[6:0]}, 8'h10);
    tick();
    do_eoi();
    tick();
    chk("t2_second", {5'd0, irq_code}, 8'h05);
    tick();
    do_eoi();

    // No nesting: higher-priority edge during service only goes pending
    pulse(7'h20);
    ticks(3);
    chk("t3_code6", {5'd0, irq_code}, 8'h06);
    pulse(7'h01);
    ticks(3);
    chk("t3_no_nest", {5'd0, irq_code}, 8'h00);
    chk("t3_pend", cfg_rdata, 8'h81);
    do_eoi();
    tick();
    chk("t3_after", {5'd0, irq_code}, 8'h01);
    tick();
    do_eoi();

    // Global enable gating and write-1-to-clear
    cfg_write(1'b0, 8'h7F);
    cfg_sel = 1'b1;
    pulse(7'h04);
    ticks(4);
    chk("t4_gie_off", {5'd0, irq_code}, 8'h00);
    chk("t4_pend", cfg_rdata, 8'h04);
    cfg_write(1'b0, 8'h84);
    tick();
    chk("t4_enable", {5'd0, irq_code}, 8'h03);
    tick();
    do_eoi();
    cfg_write(1'b0, 8'h04);
    cfg_sel = 1'b1;
    pulse(7'h04);
    ticks(2);
    cfg_write(1'b1, 8'h04);
    chk("t4_w1c", cfg_rdata, 8'h00);
    cfg_write(1'b0, 8'h84);
    ticks(3);
    chk("t4_no_disp", {5'd0, irq_code}, 8'h00);

    // Held level gives a single dispatch
    cfg_write(1'b0, 8'hFF);
    cfg_sel = 1'b1;
    irq = 7'h08;
    n_disp = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (irq_code == 3'd4) n_disp++;
    end
    do_eoi();
    ticks(4);
    if (irq_code == 3'd4) n_disp++;
    chk("t5_one_disp", 8'(n_disp), 8'h01);
    chk("t5_pend_clear", cfg_rdata, 8'h00);

    // W1C coinciding with a new edge: set wins
    cfg_write(1'b0, 8'h7F);
    irq = '0;
    ticks(3);
    cfg_sel = 1'b1;
    irq = 7'h08;
    ticks(2);
    cfg_write(1'b1, 8'h08);
    chk("t5_set_wins", cfg_rdata, 8'h08);
    cfg_write(1'b1, 8'h08);
    chk("t5_w1c_later", cfg_rdata, 8'h00);
    irq = '0;
    ticks(2);

    // Reset during the dispatch cycle
    cfg_write(1'b0, 8'h81);
    cfg_sel = 1'b1;
    pulse(7'h03);
    ticks(3);
    chk("t6_dispatch", {5'd0, irq_code}, 8'h01);
    reset = 1'b1;
    tick();
    chk("t6_code", {5'd0, irq_code}, 8'h00);
    chk("t6_insvc", {7'd0, in_service}, 8'h00);
    chk("t6_pend", cfg_rdata, 8'h00);
    cfg_sel = 1'b0;
    #1;
    chk("t6_mask", cfg_rdata, 8'h00);
    reset = 1'b0;
    ticks(3);
    chk("t6_idle", {7'd0, in_service}, 8'h00);

    // Randomized traffic against the model
    cfg_write(1'b0, 8'hFF);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) irq = irq ^ 7'($urandom_range(0, 127));
      eoi = ($urandom_range(0, 6) == 0);
      cfg_sel = 1'($urandom_range(0, 1));
      cfg_we = ($urandom_range(0, 24) == 0);
      if (cfg_sel)
        cfg_wdata = 8'($urandom_range(0, 255));
      else
        cfg_wdata = {($urandom_range(0, 3) != 0), 7'($urandom_range(0, 127))};
      tick();
    end
    cfg_we = 1'b0;
    eoi = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Upstream source of the datapath's 3-bit interrupt code input. Synchronises seven external request lines, latches rising edges as pending, and applies a mask and a global enable. Dispatches the highest-priority eligible source as a one-cycle code, during which the datapath injects the vector jump instruction. Blocks further dispatch until the control unit signals end-of-interrupt; interrupts do not nest.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per request line (minimum 2).
N_SRC, 7, number of sources. Fixed at 7 because codes 1..7 fit the 3-bit code.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high; clears all state.
irq  in  7  asynchronous external requests; irq[i] maps to code i+1.
eoi  in  1  one-cycle end-of-interrupt pulse from the control unit (return from handler).
cfg_we  in  1  configuration write strobe from the I/O decode.
cfg_sel  in  1  register select: 0 = control, 1 = pending.
cfg_wdata  in  8  configuration write data.
cfg_rdata  out  8  configuration read data, combinational on cfg_sel.
irq_code  out  3  registered; drives the datapath interrupt code; 0 = none.
in_service  out  1  registered; high while a handler is active.
active_src  out  3  registered; code of the source being serviced; 0 when idle.

Behaviour:
- Reset (synchronous, active-high): synchronisers, edge history, pending, mask, gie, irq_code, in_service and active_src all become 0; FSM goes to IDLE.
  - A reset during DISPATCH or SERVICE drops irq_code and in_service to 0 at that edge and discards all pending bits.
- Synchroniser and edge detect:
  - Each irq line passes through SYNC_STAGES flops, then a history flop.
  - edge[i] = sync_out[i] & ~hist[i]. Only rising edges count; a held-high level produces one edge.
- Pending register pend[6:0]:
  - Set by edge[i].
  - Cleared by dispatch of source i, or by a cfg write with cfg_sel=1 and cfg_wdata[i]=1 (write-1-to-clear).
  - If set and clear coincide on the same bit in the same cycle, set wins.
- Control register:
  - cfg_sel=0 write: mask[6:0] = wdata[6:0] (1 = enabled); gie = wdata[7].
  - A new value affects eligibility from the next cycle.
  - Masking a pending bit keeps the bit pending.
- Read data:
  - cfg_sel=0 reads {gie, mask}.
  - cfg_sel=1 reads {in_service, pend}.
- Eligibility and priority:
  - elig = pend & mask & {7{gie}}.
  - Priority is fixed: the lowest index wins (irq[0], code 1, is highest).
- FSM:
  - IDLE:
    - If elig != 0: latch src = priority-encoded index + 1, clear that pend bit, go to DISPATCH.
    - Otherwise stay. irq_code = 0.
  - DISPATCH:
    - irq_code = src for exactly one cycle; active_src = src; in_service = 1.
    - Next state is SERVICE unconditionally.
    - eoi is ignored in this state.
  - SERVICE:
    - irq_code = 0; in_service = 1; active_src holds.
    - On eoi: go to IDLE, clear in_service and active_src.
    - New edges, including higher-priority ones, only accumulate in pend.
- eoi in IDLE is ignored.
- Back-to-back: after eoi, the FSM spends at least one cycle in IDLE before the next DISPATCH.
- Latency with SYNC_STAGES=2:
  - irq[i] sampled high at edge k.
  - pend[i] is visible after edge k+2.
  - irq_code = i+1 after edge k+3, for one cycle only.
- Clearing gie or mask during SERVICE does not abort the handler; it only affects later dispatches.

Test Plan:
- Reset, then write cfg_sel=0 data 0x81 and pulse irq[0] → pend=0x01 after 3 edges; irq_code=1 for exactly one cycle; in_service=1; active_src=1 until eoi, then both 0.
- Mask 0xFF, raise irq[4] and irq[1] in the same cycle → irq_code=2 dispatched first; pend reads 0x10. After eoi plus one idle cycle → irq_code=5.
- During SERVICE of code 6, raise irq[0] → no dispatch, pend[0]=1, cfg_rdata(sel=1)=0x81. After eoi → irq_code=1.
- gie=0, mask=0x7F, pulse irq[2] → irq_code stays 0, pend=0x04. Write 0x84 → dispatch code 3. Separately, a W1C write of 0x04 while pending → pend=0, no dispatch.
- Hold irq[3] high for 20 cycles → exactly one dispatch of code 4. A W1C of bit 3 coinciding with a new edge on irq[3] → pend[3] remains 1.
- Assert reset in the DISPATCH cycle → irq_code=0, in_service=0, pend=0, mask=0 at the next edge; FSM is in IDLE.
